// File: rtl/char_draw_sequencer_pkg.sv
// Shared types and character FSM state codes for the player sprite sequencer.
// Also imported by the character FSM so both agree on lane/transit encoding.
package char_draw_sequencer_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ERASE,
        DRAW
    } seqState_t;

    localparam logic [3:0] POS0 = 4'd0;
    localparam logic [3:0] POS1 = 4'd1;
    localparam logic [3:0] POS2 = 4'd2;
    localparam logic [3:0] POS3 = 4'd3;
    localparam logic [3:0] T01  = 4'd4;
    localparam logic [3:0] T10  = 4'd5;
    localparam logic [3:0] T12  = 4'd6;
    localparam logic [3:0] T21  = 4'd7;
    localparam logic [3:0] T23  = 4'd8;
    localparam logic [3:0] T32  = 4'd9;

endpackage

// File: rtl/char_draw_sequencer_scan.sv
// Row-major pixel scan counter for one sprite box (px inner, py outer).
// Holds the coordinate of the next pixel to be emitted; wraps to 0 after the last.
module sprite_scan_counter #(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clear,
    input  logic       step,
    output logic [3:0] px,
    output logic [3:0] py,
    output logic       last
);

    assign last = (px == 4'(W - 1)) && (py == 4'(H - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (step) begin
            if (px == 4'(W - 1)) begin
                px <= '0;
                py <= (py == 4'(H - 1)) ? 4'd0 : py + 4'd1;
            end else begin
                px <= px + 4'd1;
            end
        end
    end

endmodule

// File: rtl/char_draw_sequencer.sv
// Drives the framebuffer write port for the player sprite: erase old lane, draw new.
// DoneDrawing stays low for the whole erase+draw so the character FSM holds its state.
module char_draw_sequencer
    import char_draw_sequencer_pkg::*;
#(
    parameter int          SPRITE_W    = 8,
    parameter int          SPRITE_H    = 8,
    parameter int          LANE_X0     = 16,
    parameter int          LANE_PITCH  = 40,
    parameter int          CHAR_Y      = 100,
    parameter logic [2:0]  CHAR_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] CurrState,
    output logic [7:0] VgaX,
    output logic [6:0] VgaY,
    output logic [2:0] VgaColour,
    output logic       VgaPlot,
    output logic       DoneDrawing
);

    seqState_t  state, nextState;
    logic [1:0] targetLane, nextTargetLane;
    logic [1:0] lastLane, nextLastLane;
    logic       lastValid, nextLastValid;
    logic       lastOut, nextLastOut;
    logic [7:0] nextX;
    logic [6:0] nextY;
    logic [2:0] nextColour;
    logic       nextPlot, nextDone;

    logic       trigger;
    logic       loadPix;
    logic [1:0] pixLane;
    logic [2:0] pixColour;
    logic       scanClear, scanStep;
    logic [3:0] px, py;
    logic       scanLast;

    sprite_scan_counter #(
        .W(SPRITE_W),
        .H(SPRITE_H)
    ) scan (
        .Clock(Clock),
        .Reset(Reset),
        .clear(scanClear),
        .step (scanStep),
        .px   (px),
        .py   (py),
        .last (scanLast)
    );

    function automatic logic [7:0] laneBase(input logic [1:0] lane);
        logic [7:0] offset;
        offset = 8'(lane) * 8'(LANE_PITCH);
        return 8'(LANE_X0) + offset;
    endfunction

    assign trigger = (state == IDLE) && (CurrState <= POS3) &&
                     (!lastValid || (CurrState[1:0] != lastLane));

    always_comb begin
        nextState      = state;
        nextTargetLane = targetLane;
        nextLastLane   = lastLane;
        nextLastValid  = lastValid;
        nextLastOut    = lastOut;
        nextX          = VgaX;
        nextY          = VgaY;
        nextColour     = VgaColour;
        nextPlot       = 1'b0;
        nextDone       = DoneDrawing;
        loadPix        = 1'b0;
        pixLane        = targetLane;
        pixColour      = CHAR_COLOUR;
        scanClear      = 1'b0;
        scanStep       = 1'b0;

        unique case (state)
            INIT: begin
                nextState      = DRAW;
                nextTargetLane = 2'd0;
                pixLane        = 2'd0;
                loadPix        = 1'b1;
            end
            IDLE: begin
                nextDone = 1'b1;
                if (trigger) begin
                    nextTargetLane = CurrState[1:0];
                    loadPix        = 1'b1;
                    if (lastValid) begin
                        nextState = ERASE;
                        pixLane   = lastLane;
                        pixColour = BG_COLOUR;
                    end else begin
                        nextState = DRAW;
                        pixLane   = CurrState[1:0];
                    end
                end else begin
                    scanClear = 1'b1;
                end
            end
            ERASE: begin
                loadPix = 1'b1;
                if (lastOut) begin
                    nextState = DRAW;
                end else begin
                    pixLane   = lastLane;
                    pixColour = BG_COLOUR;
                end
            end
            DRAW: begin
                if (lastOut) begin
                    nextState     = IDLE;
                    nextDone      = 1'b1;
                    nextLastLane  = targetLane;
                    nextLastValid = 1'b1;
                    scanClear     = 1'b1;
                end else begin
                    loadPix = 1'b1;
                end
            end
            default: nextState = INIT;
        endcase

        // Emit the counter's pending pixel and advance the scan in the same edge
        if (loadPix) begin
            nextX       = laneBase(pixLane) + {4'b0, px};
            nextY       = 7'(CHAR_Y) + {3'b0, py};
            nextColour  = pixColour;
            nextPlot    = 1'b1;
            nextDone    = 1'b0;
            nextLastOut = scanLast;
            scanStep    = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= INIT;
            targetLane  <= '0;
            lastLane    <= '0;
            lastValid   <= 1'b0;
            lastOut     <= 1'b0;
            VgaX        <= '0;
            VgaY        <= '0;
            VgaColour   <= '0;
            VgaPlot     <= 1'b0;
            DoneDrawing <= 1'b0;
        end else begin
            state       <= nextState;
            targetLane  <= nextTargetLane;
            lastLane    <= nextLastLane;
            lastValid   <= nextLastValid;
            lastOut     <= nextLastOut;
            VgaX        <= nextX;
            VgaY        <= nextY;
            VgaColour   <= nextColour;
            VgaPlot     <= nextPlot;
            DoneDrawing <= nextDone;
        end
    end

endmodule

// File: tb/tb_char_draw_sequencer.sv
// Self-checking bench: pixel scoreboard from a lane-level model, busy-time table,
// randomized lane moves, and hand sequences for mid-op changes, reset abort, small sprite.
module tb_char_draw_sequencer;

    localparam int         W     = 8;
    localparam int         H     = 8;
    localparam int         X0    = 16;
    localparam int         PITCH = 40;
    localparam int         Y0    = 100;
    localparam logic [2:0] CC    = 3'b010;
    localparam logic [2:0] BG    = 3'b000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [3:0] cs;
        int         expBusy;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset, Reset2;
    logic [3:0] CurrState, cs2;
    logic [7:0] VgaX, VgaX2;
    logic [6:0] VgaY, VgaY2;
    logic [2:0] VgaColour, VgaColour2;
    logic       VgaPlot, VgaPlot2;
    logic       DoneDrawing, DoneDrawing2;

    pix_t expQ[$];
    pix_t exp2[$];
    pix_t obs2[$];
    int   tests = 0;
    int   fails = 0;
    int   plotCnt = 0;
    int   modelLane;

    always #5 Clock = ~Clock;

    char_draw_sequencer dut (
        .Clock(Clock), .Reset(Reset), .CurrState(CurrState),
        .VgaX(VgaX), .VgaY(VgaY), .VgaColour(VgaColour),
        .VgaPlot(VgaPlot), .DoneDrawing(DoneDrawing)
    );

    char_draw_sequencer #(.SPRITE_W(3), .SPRITE_H(2)) dut2 (
        .Clock(Clock), .Reset(Reset2), .CurrState(cs2),
        .VgaX(VgaX2), .VgaY(VgaY2), .VgaColour(VgaColour2),
        .VgaPlot(VgaPlot2), .DoneDrawing(DoneDrawing2)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pushBox(input bit sel, input int lane, input logic [2:0] c,
                           input int w, input int h);
        pix_t p;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                p.x = 8'(X0 + lane * PITCH + xx);
                p.y = 7'(Y0 + yy);
                p.c = c;
                if (sel) exp2.push_back(p);
                else     expQ.push_back(p);
            end
        end
    endtask

    // Lane-level model: a move to a new lane erases the old box, draws the new one
    task automatic modelMove(input int cs, output int expBusy);
        expBusy = 0;
        if (cs <= 3 && cs != modelLane) begin
            if (modelLane >= 0) pushBox(1'b0, modelLane, BG, W, H);
            pushBox(1'b0, cs, CC, W, H);
            expBusy = (modelLane >= 0 ? 2 : 1) * W * H;
            modelLane = cs;
        end
    endtask

    task automatic waitBusy(output int busy);
        int t;
        busy = 0;
        t = 0;
        @(negedge Clock);
        while (DoneDrawing === 1'b1 && t < 3) begin
            @(negedge Clock);
            t++;
        end
        while (DoneDrawing !== 1'b1 && busy < 1000) begin
            busy++;
            @(negedge Clock);
        end
        if (busy >= 1000) begin
            tests++;
            fails++;
            $display("FAIL busyTimeout: got %0d expected <1000", busy);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset === 1'b1 && VgaPlot === 1'b1) begin
            plotCnt++;
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpectedPlot: got x=%0d y=%0d c=%0d expected none",
                         VgaX, VgaY, VgaColour);
            end else begin
                pix_t e;
                e = expQ.pop_front();
                check("pixel", int'({VgaX, VgaY, VgaColour}), int'(e));
                check("doneLowWhilePlot", int'(DoneDrawing), 0);
            end
        end
        if (Reset2 === 1'b1 && VgaPlot2 === 1'b1)
            obs2.push_back('{VgaX2, VgaY2, VgaColour2});
    end

    initial begin
        vec_t tbl[];
        int   b, eb, k, target;
        int   runs[$];
        int   lowLen, highLen, gap;
        bit   prev;

        Reset = 1'b0;
        Reset2 = 1'b0;
        CurrState = 4'd0;
        cs2 = 4'd0;
        modelLane = -1;
        repeat (3) @(negedge Clock);

        check("rstX", int'(VgaX), 0);
        check("rstY", int'(VgaY), 0);
        check("rstColour", int'(VgaColour), 0);
        check("rstPlot", int'(VgaPlot), 0);
        check("rstDone", int'(DoneDrawing), 0);

        // Power-up draw of lane 0, no erase
        modelMove(0, eb);
        Reset = 1'b1;
        waitBusy(b);
        check("initBusy", b, 64);
        check("initDrained", expQ.size(), 0);

        tbl = '{
            '{4'd4, 0}, '{4'd1, 128}, '{4'd1, 0}, '{4'd12, 0},
            '{4'd7, 0}, '{4'd2, 128}, '{4'd0, 128}, '{4'd15, 0},
            '{4'd3, 128}, '{4'd9, 0}, '{4'd1, 128}
        };
        foreach (tbl[i]) begin
            modelMove(int'(tbl[i].cs), eb);
            CurrState = tbl[i].cs;
            waitBusy(b);
            check("tblBusy", b, tbl[i].expBusy);
            check("tblModelBusy", b, eb);
            check("tblDrained", expQ.size(), 0);
            check("tblDone", int'(DoneDrawing), 1);
        end

        // Change during erase is held off until IDLE, then runs after one idle cycle
        modelMove(2, eb);
        modelMove(3, eb);
        lowLen = 0;
        highLen = 0;
        gap = -1;
        prev = 1'b1;
        CurrState = 4'd2;
        for (int c = 0; c < 400; c++) begin
            @(negedge Clock);
            if (c == 10) CurrState = 4'd3;
            if (!DoneDrawing) begin
                if (prev && runs.size() == 1) gap = highLen;
                lowLen++;
                highLen = 0;
            end else begin
                if (!prev) runs.push_back(lowLen);
                lowLen = 0;
                highLen++;
            end
            prev = DoneDrawing;
        end
        check("midRuns", runs.size(), 2);
        check("midBusy1", runs.size() > 0 ? runs[0] : -1, 128);
        check("midBusy2", runs.size() > 1 ? runs[1] : -1, 128);
        check("midGap", gap, 1);
        check("midDrained", expQ.size(), 0);

        // Abort with reset at DRAW pixel 30 of the 3 -> 0 move
        modelMove(0, eb);
        target = plotCnt + 64 + 31;
        CurrState = 4'd0;
        k = 0;
        while (plotCnt < target && k < 500) begin
            @(negedge Clock);
            k++;
        end
        check("abortReached", int'(plotCnt >= target), 1);
        #2 Reset = 1'b0;
        #1;
        check("abortPlot", int'(VgaPlot), 0);
        check("abortDone", int'(DoneDrawing), 0);
        check("abortXY", int'({VgaX, VgaY, VgaColour}), 0);
        expQ.delete();
        modelLane = -1;
        modelMove(0, eb);
        @(negedge Clock);
        Reset = 1'b1;
        waitBusy(b);
        check("redrawBusy", b, 64);
        check("redrawDrained", expQ.size(), 0);

        // Randomized lane/transit/illegal states
        for (int r = 0; r < 25; r++) begin
            int cs;
            cs = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            modelMove(cs, eb);
            CurrState = 4'(cs);
            waitBusy(b);
            check("rndBusy", b, eb);
            check("rndDrained", expQ.size(), 0);
        end

        // 3x2 sprite: initial draw, then a move to lane 1
        pushBox(1'b1, 0, CC, 3, 2);
        Reset2 = 1'b1;
        repeat (20) @(negedge Clock);
        check("smallInitCount", obs2.size(), 6);
        check("smallDone", int'(DoneDrawing2), 1);
        pushBox(1'b1, 0, BG, 3, 2);
        pushBox(1'b1, 1, CC, 3, 2);
        cs2 = 4'd1;
        repeat (30) @(negedge Clock);
        check("smallMoveCount", obs2.size(), 18);
        for (int i = 0; i < 18; i++) begin
            check("smallPix", i < obs2.size() ? int'(obs2[i]) : -1, int'(exp2[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
